// File: rtl/chess_time_counter_pkg.sv
// Shared types and constants for the chess clock time counter.
package chess_time_counter_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [15:0] DEFAULT_DIGIT_MAX = 16'h9959;

    typedef enum logic {
        ST_IDLE,
        ST_ADD
    } state_e;

endpackage

// File: rtl/chess_time_counter_bcd_digit_cell.sv
// One mixed-radix digit: next value on decrement/increment with borrow/carry
// propagation, and clamping of a load value to the digit's maximum.
module chess_time_counter_bcd_digit_cell
    import chess_time_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    input  logic [DIGIT_W-1:0] max_val,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               borrow_in,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] dec_val,
    output logic [DIGIT_W-1:0] inc_val,
    output logic [DIGIT_W-1:0] load_clamped,
    output logic               borrow_out,
    output logic               carry_out
);

    logic is_zero;
    logic is_max;

    always_comb begin
        is_zero = (value == '0);
        is_max  = (value >= max_val);

        dec_val    = value;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (is_zero) begin
                dec_val    = max_val;
                borrow_out = 1'b1;
            end else begin
                dec_val = value - DIGIT_W'(1);
            end
        end

        inc_val   = value;
        carry_out = 1'b0;
        if (carry_in) begin
            if (is_max) begin
                inc_val   = '0;
                carry_out = 1'b1;
            end else begin
                inc_val = value + DIGIT_W'(1);
            end
        end

        load_clamped = (load_val > max_val) ? max_val : load_val;
    end

endmodule

// File: rtl/chess_time_counter.sv
// One player's remaining time: cascaded mixed-radix down-counter with
// saturating flag-fall and a one-per-cycle Fischer bonus adder.
module chess_time_counter
    import chess_time_counter_pkg::*;
#(
    parameter int unsigned                 DIGITS    = 4,
    parameter logic [DIGIT_W*DIGITS-1:0]   DIGIT_MAX = DEFAULT_DIGIT_MAX,
    parameter int unsigned                 BONUS_W   = 6
) (
    input  logic                        CLK,
    input  logic                        CLR_N,
    input  logic                        LOAD,
    input  logic [DIGIT_W*DIGITS-1:0]   LOAD_VAL,
    input  logic                        RUN,
    input  logic                        TICK,
    input  logic                        BONUS,
    input  logic [BONUS_W-1:0]          BONUS_VAL,
    output logic [DIGIT_W*DIGITS-1:0]   COUNT,
    output logic                        ZERO,
    output logic                        FLAG,
    output logic                        BUSY
);

    logic [DIGIT_W*DIGITS-1:0] count_q, count_d;
    logic [DIGIT_W*DIGITS-1:0] dec_cnt, inc_cnt, load_cnt;
    logic [BONUS_W-1:0]        rem_q, rem_d;
    logic                      flag_q, flag_d;
    logic                      pend_q, pend_d;
    state_e                    state_q, state_d;

    logic [DIGITS:0] borrow;
    logic [DIGITS:0] carry;
    logic            all_zero;
    logic            all_max;
    logic            tick_run;
    logic            do_dec;

    // Chains seeded with 1: borrow out of the top digit means the whole
    // count is zero, carry out of the top digit means every digit is at max.
    assign borrow[0] = 1'b1;
    assign carry[0]  = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        chess_time_counter_bcd_digit_cell u_cell (
            .value        (count_q[DIGIT_W*i +: DIGIT_W]),
            .max_val      (DIGIT_MAX[DIGIT_W*i +: DIGIT_W]),
            .load_val     (LOAD_VAL[DIGIT_W*i +: DIGIT_W]),
            .borrow_in    (borrow[i]),
            .carry_in     (carry[i]),
            .dec_val      (dec_cnt[DIGIT_W*i +: DIGIT_W]),
            .inc_val      (inc_cnt[DIGIT_W*i +: DIGIT_W]),
            .load_clamped (load_cnt[DIGIT_W*i +: DIGIT_W]),
            .borrow_out   (borrow[i+1]),
            .carry_out    (carry[i+1])
        );
    end

    assign all_zero = borrow[DIGITS];
    assign all_max  = carry[DIGITS];
    assign tick_run = TICK & RUN;

    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        state_d = state_q;
        pend_d  = pend_q;
        rem_d   = rem_q;
        do_dec  = 1'b0;

        if (LOAD) begin
            count_d = load_cnt;
            flag_d  = 1'b0;
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            rem_d   = '0;
        end else if (!flag_q) begin
            case (state_q)
                ST_IDLE: begin
                    // A tick parked during ADD is consumed here; a fresh tick
                    // on this same cycle stays parked for the next one.
                    do_dec = tick_run | pend_q;
                    pend_d = pend_q & tick_run;
                    if (do_dec && !all_zero) begin
                        count_d = dec_cnt;
                        if (dec_cnt == '0) begin
                            flag_d = 1'b1;
                        end
                    end
                    if (BONUS && (BONUS_VAL != '0) && !flag_d) begin
                        state_d = ST_ADD;
                        rem_d   = BONUS_VAL;
                    end
                end
                ST_ADD: begin
                    if (!all_max) begin
                        count_d = inc_cnt;
                    end
                    rem_d = rem_q - BONUS_W'(1);
                    if (rem_q == BONUS_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                    if (tick_run) begin
                        pend_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            count_q <= '0;
            flag_q  <= 1'b0;
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            rem_q   <= rem_d;
        end
    end

    assign COUNT = count_q;
    assign ZERO  = all_zero;
    assign FLAG  = flag_q;
    assign BUSY  = (state_q == ST_ADD);

endmodule

// File: tb/tb_chess_time_counter.sv
// Bench for chess_time_counter: reference model tracks remaining time as a
// plain tick count and converts to/from the mixed-radix display form.
module tb_chess_time_counter;

    localparam int unsigned DIGITS = 4;
    localparam logic [15:0] DMAX   = 16'h9959;
    localparam int unsigned BW     = 6;

    logic        CLK = 1'b0;
    logic        CLR_N;
    logic        LOAD;
    logic [15:0] LOAD_VAL;
    logic        RUN;
    logic        TICK;
    logic        BONUS;
    logic [5:0]  BONUS_VAL;
    logic [15:0] COUNT;
    logic        ZERO;
    logic        FLAG;
    logic        BUSY;

    int test_cnt = 0;
    int fail_cnt = 0;

    int m_t;
    bit m_flag;
    int m_left;
    bit m_pend;
    int maxt;

    always #5 CLK = ~CLK;

    chess_time_counter #(
        .DIGITS    (DIGITS),
        .DIGIT_MAX (DMAX),
        .BONUS_W   (BW)
    ) dut (
        .CLK       (CLK),
        .CLR_N     (CLR_N),
        .LOAD      (LOAD),
        .LOAD_VAL  (LOAD_VAL),
        .RUN       (RUN),
        .TICK      (TICK),
        .BONUS     (BONUS),
        .BONUS_VAL (BONUS_VAL),
        .COUNT     (COUNT),
        .ZERO      (ZERO),
        .FLAG      (FLAG),
        .BUSY      (BUSY)
    );

    function automatic int radix(int i);
        logic [15:0] d;
        d = DMAX;
        return int'((d >> (4 * i)) & 16'hF) + 1;
    endfunction

    function automatic logic [15:0] to_bcd(int t);
        logic [15:0] res;
        int rem;
        res = '0;
        rem = t;
        for (int i = 0; i < int'(DIGITS); i++) begin
            res[4*i +: 4] = 4'(rem % radix(i));
            rem = rem / radix(i);
        end
        return res;
    endfunction

    // Includes the per-digit clamp applied to load values.
    function automatic int to_ticks(logic [15:0] v);
        int sum;
        int w;
        int dig;
        sum = 0;
        w   = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = int'((v >> (4 * i)) & 16'hF);
            if (dig > radix(i) - 1) dig = radix(i) - 1;
            sum += dig * w;
            w   *= radix(i);
        end
        return sum;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        test_cnt++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("count", COUNT, to_bcd(m_t));
        check("zero", 16'(ZERO), 16'(m_t == 0));
        check("flag", 16'(FLAG), 16'(m_flag));
        check("busy", 16'(BUSY), 16'(m_left > 0));
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_flag = 1'b0;
        m_left = 0;
        m_pend = 1'b0;
    endtask

    task automatic model_edge();
        bit tr;
        bit dec;
        tr = TICK && RUN;
        if (LOAD) begin
            m_t    = to_ticks(LOAD_VAL);
            m_flag = 1'b0;
            m_left = 0;
            m_pend = 1'b0;
        end else if (!m_flag) begin
            if (m_left > 0) begin
                if (m_t < maxt) m_t++;
                m_left--;
                if (tr) m_pend = 1'b1;
            end else begin
                dec    = tr || m_pend;
                m_pend = m_pend && tr;
                if (dec && m_t > 0) begin
                    m_t--;
                    if (m_t == 0) m_flag = 1'b1;
                end
                if (BONUS && BONUS_VAL != 0 && !m_flag) m_left = int'(BONUS_VAL);
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
        LOAD  = 1'b0;
        TICK  = 1'b0;
        BONUS = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        LOAD     = 1'b1;
        LOAD_VAL = v;
        cycle();
    endtask

    task automatic do_tick();
        TICK = 1'b1;
        cycle();
    endtask

    task automatic do_bonus(input logic [5:0] v);
        BONUS     = 1'b1;
        BONUS_VAL = v;
        cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        maxt      = to_ticks(16'hFFFF);
        CLR_N     = 1'b0;
        LOAD      = 1'b0;
        LOAD_VAL  = '0;
        RUN       = 1'b0;
        TICK      = 1'b0;
        BONUS     = 1'b0;
        BONUS_VAL = '0;
        model_reset();
        #12;
        check_all();
        @(negedge CLK);
        CLR_N = 1'b1;
        RUN   = 1'b1;

        // Borrow across the minutes boundary
        do_load(16'h0100);
        do_tick();
        check("plan_0059", COUNT, 16'h0059);

        // Flag-fall, saturation at zero, frozen bonus, LOAD clears flag
        do_load(16'h0002);
        do_tick();
        do_tick();
        check("plan_flag_set", 16'(FLAG), 16'h0001);
        do_tick();
        check("plan_hold_zero", COUNT, 16'h0000);
        do_bonus(6'd5);
        idle(2);
        check("plan_bonus_ignored", COUNT, 16'h0000);
        do_load(16'h0500);
        check("plan_flag_clear", 16'(FLAG), 16'h0000);

        // Bonus with carry into minutes
        do_load(16'h0058);
        do_bonus(6'd5);
        idle(6);
        check("plan_0103", COUNT, 16'h0103);

        // Bonus saturating at all-max
        do_load(16'h9957);
        do_bonus(6'd10);
        idle(11);
        check("plan_sat_9959", COUNT, 16'h9959);

        // Tick parked during ADD, second tick in same ADD dropped
        do_load(16'h0010);
        do_bonus(6'd3);
        do_tick();
        do_tick();
        cycle();
        check("plan_0013", COUNT, 16'h0013);
        cycle();
        check("plan_0012", COUNT, 16'h0012);
        idle(2);

        // Load clamps out-of-range digits
        do_load(16'hFAFF);
        check("plan_clamp", COUNT, 16'h9959);

        // LOAD aborts ADD
        do_load(16'h0300);
        do_bonus(6'd20);
        idle(3);
        do_load(16'h0200);
        check("plan_load_abort", COUNT, 16'h0200);
        check("plan_load_busy", 16'(BUSY), 16'h0000);

        // Asynchronous reset mid-ADD
        do_bonus(6'd20);
        idle(2);
        #2;
        CLR_N = 1'b0;
        #1;
        model_reset();
        check_all();
        check("plan_clr_count", COUNT, 16'h0000);
        @(negedge CLK);
        CLR_N = 1'b1;

        // Randomised traffic
        repeat (800) begin
            RUN       = ($urandom % 5) != 0;
            TICK      = ($urandom % 3) == 0;
            BONUS     = ($urandom % 8) == 0;
            BONUS_VAL = (($urandom % 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            LOAD      = ($urandom % 40) == 0;
            LOAD_VAL  = (($urandom % 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
